rr_arb_mux: RTL and testbench

RR_ARB_MUX -- requirements
Module: rr_arb_mux

---
 rtl/rr_arb_mux.sv | 91 +++++++++
 tb/tb_rr_arb_mux.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel arbiter feeding a single registered output stage.
// MODE 0 grants the lowest-index valid channel; MODE 1 rotates priority so
// the channel after the last winner is searched first. in_ready is a
// combinational function of out_ready (no skid buffer), so upstream sees
// backpressure in the same cycle.
module rr_arb_mux #(
  parameter int WIDTH = 65,
  parameter int N     = 2,
  parameter int MODE  = 1,
  localparam int SELW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);

  logic             load_en;
  logic             found;
  logic [N-1:0]     grant;
  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  start;
  logic [SELW-1:0]  gnt_idx;
  logic [WIDTH-1:0] gnt_data;

  assign load_en = !out_valid || out_ready;
  assign start   = (MODE == 0) ? '0 : ptr;

  // The whole register is gated by rst_n so nothing is accepted while the
  // block is held in reset, even though out_valid is already low.
  assign in_ready = grant & {N{load_en & rst_n}};

  // Priority search: first pass covers channels at or above the start
  // index, second pass wraps around to the channels below it.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    gnt_idx  = '0;
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && in_valid[i] && (i >= int'(start))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        gnt_idx  = SELW'(i);
        gnt_data = in_data[i*WIDTH +: WIDTH];
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && in_valid[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        gnt_idx  = SELW'(i);
        gnt_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register: load on transfer, drain when empty-handed, hold under
  // backpressure. Payload and index keep their last values when draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (load_en) begin
      if (found) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_sel   <= gnt_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // Round-robin pointer: moves to the channel after the winner on each
  // transfer, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if ((MODE == 1) && load_en && found) begin
      ptr <= (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + SELW'(1);
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: round-robin and fixed-priority N=2
// instances plus a round-robin N=4 instance for pointer wrap-around.
module tb_rr_arb_mux;

  logic clk;
  logic rst_n;

  localparam logic [64:0] DATA_A    = 65'h0_1111_2222_3333_4444;
  localparam logic [64:0] DATA_B    = 65'h1_5555_6666_7777_8888;
  localparam logic [64:0] DATA_BEEF = 65'h1_0000_0000_DEAD_BEEF;
  localparam logic [64:0] DATA_C    = 65'h0_0000_0000_0000_0C0C;
  localparam logic [64:0] DATA_D    = 65'h1_0000_0000_0000_0D0D;
  localparam logic [64:0] DATA_E    = 65'h0_EEEE_EEEE_EEEE_EEEE;

  // N=2 round-robin instance
  logic [1:0]   rr_valid;
  logic [64:0]  rr_d0, rr_d1;
  logic [1:0]   rr_ready;
  logic         rr_ovalid;
  logic [64:0]  rr_odata;
  logic [0:0]   rr_osel;
  logic         rr_oready;

  // N=2 fixed-priority instance
  logic [1:0]   fp_valid;
  logic [64:0]  fp_d0, fp_d1;
  logic [1:0]   fp_ready;
  logic         fp_ovalid;
  logic [64:0]  fp_odata;
  logic [0:0]   fp_osel;
  logic         fp_oready;

  // N=4 round-robin instance, 8-bit data
  logic [3:0]   q_valid;
  logic [31:0]  q_data;
  logic [3:0]   q_ready;
  logic         q_ovalid;
  logic [7:0]   q_odata;
  logic [1:0]   q_osel;
  logic         q_oready;

  int checks   = 0;
  int failures = 0;

  rr_arb_mux #(.WIDTH(65), .N(2), .MODE(1)) u_rr2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(rr_valid), .in_data({rr_d1, rr_d0}), .in_ready(rr_ready),
    .out_valid(rr_ovalid), .out_data(rr_odata), .out_sel(rr_osel),
    .out_ready(rr_oready)
  );

  rr_arb_mux #(.WIDTH(65), .N(2), .MODE(0)) u_fp2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(fp_valid), .in_data({fp_d1, fp_d0}), .in_ready(fp_ready),
    .out_valid(fp_ovalid), .out_data(fp_odata), .out_sel(fp_osel),
    .out_ready(fp_oready)
  );

  rr_arb_mux #(.WIDTH(8), .N(4), .MODE(1)) u_rr4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(q_valid), .in_data(q_data), .in_ready(q_ready),
    .out_valid(q_ovalid), .out_data(q_odata), .out_sel(q_osel),
    .out_ready(q_oready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [0:0] rr_seq [4];
    rr_seq = '{1'b0, 1'b1, 1'b0, 1'b1};

    rst_n     = 1'b0;
    rr_valid  = '0; rr_d0 = '0; rr_d1 = '0; rr_oready = 1'b1;
    fp_valid  = '0; fp_d0 = '0; fp_d1 = '0; fp_oready = 1'b1;
    q_valid   = '0; q_data = '0; q_oready = 1'b1;

    // Reset state, with a request pending to prove in_ready stays low
    #2;
    rr_valid = 2'b01;
    rr_d0    = DATA_A;
    #1;
    chk("rst_out_valid", rr_ovalid, 1'b0);
    chk("rst_out_data",  rr_odata,  65'd0);
    chk("rst_out_sel",   rr_osel,   1'b0);
    chk("rst_in_ready",  rr_ready,  2'b00);
    rr_valid = 2'b00;
    rst_n    = 1'b1;
    tick();

    // Round-robin alternation, one beat per clock
    rr_valid = 2'b11;
    rr_d0    = DATA_A;
    rr_d1    = DATA_B;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rr_in_ready", rr_ready, (rr_seq[k] == 1'b1) ? 2'b10 : 2'b01);
      tick();
      chk("rr_out_valid", rr_ovalid, 1'b1);
      chk("rr_out_sel",   rr_osel,   rr_seq[k]);
      chk("rr_out_data",  rr_odata,  (rr_seq[k] == 1'b1) ? DATA_B : DATA_A);
    end
    rr_valid = 2'b00;

    // Single beat on channel 0 (pointer back at 0)
    rr_valid = 2'b01;
    rr_d0    = DATA_BEEF;
    #1;
    chk("single_in_ready", rr_ready, 2'b01);
    tick();
    rr_valid = 2'b00;
    chk("single_out_valid", rr_ovalid, 1'b1);
    chk("single_out_data",  rr_odata,  DATA_BEEF);
    chk("single_out_sel",   rr_osel,   1'b0);

    // Backpressure for three cycles
    rr_oready = 1'b0;
    rr_valid  = 2'b11;
    rr_d0     = DATA_C;
    rr_d1     = DATA_D;
    #1;
    chk("bp_in_ready_0", rr_ready, 2'b00);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_out_valid", rr_ovalid, 1'b1);
      chk("bp_out_data",  rr_odata,  DATA_BEEF);
      chk("bp_out_sel",   rr_osel,   1'b0);
      chk("bp_in_ready",  rr_ready,  2'b00);
    end
    rr_oready = 1'b1;
    #1;
    chk("bp_release_in_ready", rr_ready, 2'b10);
    tick();
    chk("bp_release_sel",  rr_osel,  1'b1);
    chk("bp_release_data", rr_odata, DATA_D);
    rr_valid = 2'b01;
    #1;
    chk("bp_next_in_ready", rr_ready, 2'b01);
    tick();
    chk("bp_next_sel",  rr_osel,  1'b0);
    chk("bp_next_data", rr_odata, DATA_C);
    rr_valid = 2'b00;

    // Drain with no grant: valid drops, payload and index hold
    tick();
    chk("idle_out_valid", rr_ovalid, 1'b0);
    chk("idle_out_data",  rr_odata,  DATA_C);
    chk("idle_out_sel",   rr_osel,   1'b0);

    // Load a beat, then assert reset mid-stream between clock edges
    rr_valid = 2'b10;
    rr_d1    = DATA_E;
    tick();
    chk("pre_rst_out_valid", rr_ovalid, 1'b1);
    chk("pre_rst_out_sel",   rr_osel,   1'b1);
    rr_valid = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", rr_ovalid, 1'b0);
    chk("midrst_out_data",  rr_odata,  65'd0);
    chk("midrst_out_sel",   rr_osel,   1'b0);
    chk("midrst_in_ready",  rr_ready,  2'b00);
    rr_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    // Fixed priority: channel 0 always wins
    @(negedge clk);
    fp_valid = 2'b11;
    fp_d0    = 65'd5;
    fp_d1    = 65'd6;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("fp_in_ready", fp_ready, 2'b01);
      tick();
      chk("fp_out_valid", fp_ovalid, 1'b1);
      chk("fp_out_sel",   fp_osel,   1'b0);
      chk("fp_out_data",  fp_odata,  65'd5);
    end
    fp_valid = 2'b00;

    // N=4 wrap-around: win on channel 2 puts the pointer at 3
    @(negedge clk);
    q_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    q_valid = 4'b0100;
    #1;
    chk("q_first_in_ready", q_ready, 4'b0100);
    tick();
    chk("q_first_sel",  q_osel,  2'd2);
    chk("q_first_data", q_odata, 8'hA2);
    q_valid = 4'b0101;
    #1;
    chk("q_wrap_in_ready", q_ready, 4'b0001);
    tick();
    chk("q_wrap_sel",  q_osel,  2'd0);
    chk("q_wrap_data", q_odata, 8'hA0);
    q_valid = 4'b0110;
    #1;
    chk("q_after_wrap_in_ready", q_ready, 4'b0010);
    tick();
    chk("q_after_wrap_sel",  q_osel,  2'd1);
    chk("q_after_wrap_data", q_odata, 8'hA1);
    q_valid = 4'b0100;
    #1;
    chk("q_last_in_ready", q_ready, 4'b0100);
    tick();
    chk("q_last_sel",  q_osel,  2'd2);
    q_valid = 4'b0000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
